// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, port owner
// and the load/store access-type codes used by the core.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Access-type codes match the core's load/store funct3 encoding
   localparam logic [2:0] DMT_B  = 3'b000;
   localparam logic [2:0] DMT_H  = 3'b001;
   localparam logic [2:0] DMT_W  = 3'b010;
   localparam logic [2:0] DMT_BU = 3'b100;
   localparam logic [2:0] DMT_HU = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory-side signals.
// slave = arbiter view, master = core + memory environment view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [2:0]        d_dmtype;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              bus_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_dmtype;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_dmtype,
             mem_ack, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, bus_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_dmtype,
             mem_ack, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, bus_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant choice: data wins unless fetch is pending and starved.
// Grants are one-hot or none.
module mem_arb_pick (
   input  logic i_ireq,
   input  logic i_dreq,
   input  logic i_starved,
   output logic o_grant_i,
   output logic o_grant_d
);
   assign o_grant_d = i_dreq & ~(i_ireq & i_starved);
   assign o_grant_i = i_ireq & ~o_grant_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for one single-ported memory, registered outputs.
// Optional MEM_TIMEOUT_EN: WAIT aborts with bus_err after TIMEOUT_CYC cycles.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int STARVE_LIM  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int SCW = $clog2(STARVE_LIM + 1);
   localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIM);

   arb_state_e        r_state;
   owner_e            r_owner;
   logic [SCW-1:0]    r_starve_cnt;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [2:0]        r_mem_dmtype;
   logic              r_i_ack;
   logic              r_d_ack;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_bus_err;

   logic w_starved;
   logic w_grant_i;
   logic w_grant_d;

   assign w_starved = (r_starve_cnt == STARVE_MAX);

   mem_arb_pick u_pick (
      .i_ireq    (bus.i_req),
      .i_dreq    (bus.d_req),
      .i_starved (w_starved),
      .o_grant_i (w_grant_i),
      .o_grant_d (w_grant_d)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] r_wait_cnt;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^TIMEOUT_CYC;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWN_I;
         r_starve_cnt <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_dmtype <= '0;
         r_i_ack      <= 1'b0;
         r_d_ack      <= 1'b0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
         r_bus_err    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_wait_cnt   <= '0;
`endif
      end else begin
         // acks and bus_err are single-cycle pulses
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_bus_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_d) begin
                  r_owner      <= OWN_D;
                  r_mem_req    <= 1'b1;
                  r_mem_we     <= bus.d_we;
                  r_mem_addr   <= bus.d_addr;
                  r_mem_wdata  <= bus.d_wdata;
                  r_mem_dmtype <= bus.d_dmtype;
                  r_state      <= ST_WAIT;
                  // a D grant with I pending can only happen below the limit
                  if (bus.i_req)
                     r_starve_cnt <= r_starve_cnt + SCW'(1);
               end else if (w_grant_i) begin
                  r_owner      <= OWN_I;
                  r_mem_req    <= 1'b1;
                  r_mem_we     <= 1'b0;
                  r_mem_addr   <= bus.i_addr;
                  r_mem_wdata  <= '0;
                  r_mem_dmtype <= DMT_W;
                  r_state      <= ST_WAIT;
                  r_starve_cnt <= '0;
               end
`ifdef MEM_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
            end
            ST_WAIT: begin
               if (bus.mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_RESP;
                  if (r_owner == OWN_I) begin
                     r_i_rdata <= bus.mem_rdata;
                     r_i_ack   <= 1'b1;
                  end else begin
                     if (!r_mem_we)
                        r_d_rdata <= bus.mem_rdata;
                     r_d_ack <= 1'b1;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (r_wait_cnt == TMO_LAST) begin
                  r_mem_req <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_state   <= ST_RESP;
                  if (r_owner == OWN_I) begin
                     r_i_rdata <= '0;
                     r_i_ack   <= 1'b1;
                  end else begin
                     r_d_rdata <= '0;
                     r_d_ack   <= 1'b1;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + TW'(1);
               end
`endif
            end
            // requests are not sampled here, so a requester dropping req
            // after its ack cannot be granted twice
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.i_ack      = r_i_ack;
   assign bus.i_rdata    = r_i_rdata;
   assign bus.d_ack      = r_d_ack;
   assign bus.d_rdata    = r_d_rdata;
   assign bus.bus_err    = r_bus_err;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.mem_dmtype = r_mem_dmtype;

endmodule
